// File: rtl/lut_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_sequencer
// Description : Bank of runtime-reconfigurable K-input LUTs, loaded serially
//               (MSB first) from host words, with a registered evaluate port.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_cfg_sequencer #(
    parameter int LUT_K   = 2,
    parameter int NUM_LUT = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [(2**LUT_K)-1:0] cfg_init,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic                  busy,
    input  logic [IDX_W-1:0]      eval_idx,
    input  logic [LUT_K-1:0]      eval_i,
    output logic                  eval_o,
    output logic                  eval_vld
);

    localparam int c_W     = 2**LUT_K;
    localparam int c_CNT_W = (c_W > 1) ? $clog2(c_W) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ready;
    logic               w_ready_nxt;
    logic [IDX_W-1:0]   r_tgt;
    logic [c_W-1:0]     r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_eval_o;
    logic               r_eval_vld;

    logic               w_accept;
    logic               w_shift;
    logic               w_tgt_in_range;
    logic               w_eval_in_range;
    logic               w_eval_ok;
    logic [(2**IDX_W)-1:0] w_bits;

    assign w_accept        = cfg_valid && r_ready && (r_state == c_IDLE);
    assign w_shift         = (r_state == c_SHIFT);
    assign w_tgt_in_range  = ({1'b0, r_tgt} < (IDX_W+1)'(NUM_LUT));
    assign w_eval_in_range = ({1'b0, eval_idx} < (IDX_W+1)'(NUM_LUT));
    assign w_eval_ok       = w_eval_in_range && !(w_shift && (eval_idx == r_tgt));

    // State register; ready is registered so it stays low throughout reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_SHIFT;
            c_SHIFT: if (r_cnt == '0) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == c_IDLE);
        cfg_done    = (r_state == c_DONE);
        cfg_err     = (r_state == c_DONE) && !w_tgt_in_range;
        busy        = (r_state != c_IDLE);
    end

    assign cfg_ready = r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tgt   <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_tgt   <= cfg_idx;
            r_shreg <= cfg_init;
            r_cnt   <= c_CNT_W'(c_W - 1);
        end else if (w_shift) begin
            r_shreg <= r_shreg << 1;
            if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_LUT; g++) begin : g_lut
        logic [c_W-1:0] r_lut;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_lut <= '0;
            end else if (w_shift && (r_tgt == IDX_W'(g))) begin
                r_lut <= {r_lut[c_W-2:0], r_shreg[c_W-1]};
            end
        end

        assign w_bits[g] = r_lut[eval_i];
    end

    // Unpopulated index slots read as 0; they are never loaded into eval_o.
    if ((2**IDX_W) > NUM_LUT) begin : g_pad
        for (genvar p = NUM_LUT; p < (2**IDX_W); p++) begin : g_pad_bit
            assign w_bits[p] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eval_o   <= 1'b0;
            r_eval_vld <= 1'b0;
        end else begin
            r_eval_vld <= w_eval_ok;
            if (w_eval_ok) r_eval_o <= w_bits[eval_idx];
        end
    end

    assign eval_o   = r_eval_o;
    assign eval_vld = r_eval_vld;

endmodule
`default_nettype wire
